// File: rtl/icache_direct.sv
// icache_direct: direct-mapped one-word-line I-cache; define ICACHE_STATS_EN for hit/miss counters
module icache_direct #(
  parameter int SETS = 16,
  parameter bit PC_RESET_TAG_CLR = 1'b1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [0:0] IDLE = 1'b0, FETCH = 1'b1;
  logic [0:0] state;
  logic [SETS-1:0] valid;
  logic [TAG_W-1:0] tags [SETS];
  logic [31:0] data [SETS];
  logic [29:0] miss_word;
  logic [IDX_W-1:0] idx, fidx;
  logic [TAG_W-1:0] tag, ftag;
  logic hit, miss, fill, unused_bits;
  assign idx = imemaddr[IDX_W+1:2];
  assign tag = imemaddr[31:IDX_W+2];
  assign fidx = miss_word[IDX_W-1:0];
  assign ftag = miss_word[29:IDX_W];
  assign unused_bits = ^imemaddr[1:0];
  assign hit = imemREN & valid[idx] & (tags[idx] == tag);
  assign miss = (state == IDLE) & imemREN & !hit;
  // an abort (imemREN low) suppresses a fill completing in the same cycle
  assign fill = (state == FETCH) & imemREN & !iwait;
  assign ihit = (state == IDLE) & hit;
  assign imemload = (state == IDLE) ? data[idx] : iload;
  assign iREN = (state == FETCH);
  assign iaddr = (state == FETCH) ? {miss_word, 2'b00} : 32'd0;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      valid <= '0;
      miss_word <= '0;
    end else if (state == IDLE) begin
      if (miss) begin
        state <= FETCH;
        miss_word <= imemaddr[31:2];
      end
    end else begin
      if (!imemREN || !iwait) state <= IDLE;
      if (fill) valid[fidx] <= 1'b1;
    end
  end
  if (PC_RESET_TAG_CLR) begin : g_tag_clr
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) for (int i = 0; i < SETS; i++) tags[i] <= '0;
      else if (fill) tags[fidx] <= ftag;
    end
  end else begin : g_tag_keep
    always_ff @(posedge CLK) begin
      if (fill) tags[fidx] <= ftag;
    end
  end
  always_ff @(posedge CLK) begin
    if (fill) data[fidx] <= iload;
  end
`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      if (ihit && ~&hit_count) hit_count <= hit_count + 32'd1;
      if (miss && ~&miss_count) miss_count <= miss_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: directed stimulus with a hit-data scoreboard checked by a separate monitor
module tb_icache_direct;
  logic CLK, nRST, imemREN, ihit, iREN, iwait;
  logic [31:0] imemaddr, imemload, iaddr, iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif
  int total = 0, bad = 0;
  logic [31:0] q[$];
  logic [31:0] exp_load;

  icache_direct dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload)
`ifdef ICACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // monitor: every ihit cycle must match the next expected word
  always @(negedge CLK) begin
    if (ihit) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_hit got=%h expected=no_hit t=%0t", imemload, $time);
      end else begin
        exp_load = q.pop_front();
        if (imemload !== exp_load) begin
          bad++;
          $display("FAIL hit_data got=%h expected=%h t=%0t", imemload, exp_load, $time);
        end
      end
    end
  end

  task automatic hold_hits(input logic [31:0] d, input int n);
    for (int k = 0; k < n; k++) begin
      q.push_back(d);
      @(negedge CLK);
      #1;
      chk("hit_seen", 32'(q.size()), 32'd0);
      chk("hit_iren", {31'd0, iREN}, 32'd0);
      step();
    end
    q.delete();
    imemREN = 1'b0;
  endtask

  task automatic hit(input logic [31:0] a, input logic [31:0] d, input int n);
    imemREN = 1'b1;
    imemaddr = a;
    hold_hits(d, n);
  endtask

  task automatic miss_fill(input logic [31:0] a, input logic [31:0] d, input int waits, input int nhit);
    imemREN = 1'b1;
    imemaddr = a;
    iwait = 1'b1;
    iload = 32'hDEAD_BEEF;
    @(negedge CLK);
    chk("miss_ihit", {31'd0, ihit}, 32'd0);
    chk("miss_iren", {31'd0, iREN}, 32'd0);
    step();
    for (int k = 0; k <= waits; k++) begin
      iwait = (k < waits);
      iload = (k < waits) ? 32'hDEAD_BEEF : d;
      @(negedge CLK);
      chk("fetch_iren", {31'd0, iREN}, 32'd1);
      chk("fetch_iaddr", iaddr, {a[31:2], 2'b00});
      chk("fetch_ihit", {31'd0, ihit}, 32'd0);
      chk("fetch_load", imemload, iload);
      step();
    end
    iwait = 1'b1;
    iload = 32'hDEAD_BEEF;
    hold_hits(d, nhit);
  endtask

  task automatic abort(input logic [31:0] a, input bit same_cycle);
    imemREN = 1'b1;
    imemaddr = a;
    iwait = 1'b1;
    @(negedge CLK);
    chk("abort_miss", {31'd0, ihit}, 32'd0);
    step();
    @(negedge CLK);
    chk("abort_fetch", {31'd0, iREN}, 32'd1);
    step();
    imemREN = 1'b0;
    if (same_cycle) begin
      iwait = 1'b0;
      iload = 32'h1111_2222;
    end
    @(negedge CLK);
    chk("abort_still", {31'd0, iREN}, 32'd1);
    step();
    iwait = 1'b0;
    iload = 32'h3333_4444;
    @(negedge CLK);
    chk("abort_idle", {31'd0, iREN}, 32'd0);
    step();
    iwait = 1'b1;
  endtask

  initial begin
    nRST = 1'b0;
    imemREN = 1'b0;
    imemaddr = 32'd0;
    iwait = 1'b1;
    iload = 32'd0;
    @(negedge CLK);
    chk("rst_ihit", {31'd0, ihit}, 32'd0);
    chk("rst_iren", {31'd0, iREN}, 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    step();
    nRST = 1'b1;
    step();
    // cold miss, 3 wait cycles, then 5 hit cycles
    miss_fill(32'h0000_0040, 32'h2008_0005, 3, 5);
`ifdef ICACHE_STATS_EN
    chk("stat_miss", miss_count, 32'd1);
    chk("stat_hit", hit_count, 32'd5);
`endif
    hit(32'h0000_0040, 32'h2008_0005, 2);
    hit(32'h0000_0043, 32'h2008_0005, 1);
    // conflict on index 0
    miss_fill(32'h0000_0440, 32'hCAFE_0440, 1, 1);
    miss_fill(32'h0000_0040, 32'h2008_0005, 0, 1);
    // aborts: plain, then abort coinciding with a completing fill
    abort(32'h0000_0084, 1'b0);
    miss_fill(32'h0000_0084, 32'hABCD_0084, 2, 1);
    abort(32'h0000_0088, 1'b1);
    miss_fill(32'h0000_0088, 32'h5555_0088, 0, 1);
    hit(32'h0000_0084, 32'hABCD_0084, 1);
    // asynchronous reset mid-FETCH
    hit(32'h0000_0040, 32'h2008_0005, 1);
    imemREN = 1'b1;
    imemaddr = 32'h0000_00C8;
    step();
    @(negedge CLK);
    chk("pre_rst_iren", {31'd0, iREN}, 32'd1);
    #1;
    nRST = 1'b0;
    #1;
    chk("async_iren", {31'd0, iREN}, 32'd0);
    chk("async_iaddr", iaddr, 32'd0);
    chk("async_ihit", {31'd0, ihit}, 32'd0);
    imemREN = 1'b0;
    step();
    nRST = 1'b1;
    step();
    miss_fill(32'h0000_0040, 32'h7777_0040, 1, 1);
`ifdef ICACHE_STATS_EN
    chk("stat_miss_rst", miss_count, 32'd1);
    chk("stat_hit_rst", hit_count, 32'd1);
`endif
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
